// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared types and command constants for the UART register decoder
package uart_cmd_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_VAL = 1'b1
  } state_t;

  localparam logic [7:0] CMD_WR_BASE = 8'h41;
  localparam logic [7:0] CMD_RD_BASE = 8'h61;
  localparam logic [7:0] CMD_NOP     = 8'h00;

  // Bytes below base wrap to large offsets, so one compare covers both ends.
  function automatic logic cmd_in_range(input logic [7:0] b, input logic [7:0] base,
                                        input int n);
    logic [7:0] off;
    off = b - base;
    return (int'(off) < n);
  endfunction

endpackage

// File: rtl/uart_cmd_txslot.sv
// rtl/uart_cmd_txslot.sv - single-entry valid/ready TX holding register with overrun flag
module uart_cmd_txslot (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req,
  input  logic [7:0] i_req_data,
  input  logic       i_tx_ready,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_data,
  output logic       o_err_overrun
);

  logic       r_valid;
  logic [7:0] r_data;
  logic       r_overrun;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid   <= 1'b0;
      r_data    <= 8'h00;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (i_req) begin
        // A request only lands if the slot is empty or draining this cycle.
        if (r_valid && !i_tx_ready) begin
          r_overrun <= 1'b1;
        end else begin
          r_valid <= 1'b1;
          r_data  <= i_req_data;
        end
      end else if (r_valid && i_tx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_tx_valid    = r_valid;
  assign o_tx_data     = r_data;
  assign o_err_overrun = r_overrun;

endmodule

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - ASCII register protocol decoder with register bank and TX slot
// Optional: define UART_CMD_ECHO_EN to echo every written value back over TX.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int NUM_REGS       = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_tx_ready,
  output logic                  o_tx_valid,
  output logic [7:0]            o_tx_data,
  output logic [NUM_REGS*8-1:0] o_regs_out,
  output logic                  o_wr_strobe,
  output logic [IW-1:0]         o_wr_index,
  output logic                  o_err_cmd,
  output logic                  o_err_timeout,
  output logic                  o_err_overrun
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [7:0]    r_regs [NUM_REGS];
  logic          r_wr_strobe;
  logic [IW-1:0] r_wr_index;
  logic          r_err_cmd;
  logic          r_err_timeout;

  logic          w_is_wr, w_is_rd, w_expired;
  logic [IW-1:0] w_wr_idx, w_rd_idx;
  logic          w_idx_load, w_wr_en, w_rd_req, w_cmd_err, w_tmo;
  logic          w_tx_req;
  logic [7:0]    w_tx_data;

  assign w_is_wr   = cmd_in_range(i_rx_data, CMD_WR_BASE, NUM_REGS);
  assign w_is_rd   = cmd_in_range(i_rx_data, CMD_RD_BASE, NUM_REGS);
  assign w_wr_idx  = IW'(i_rx_data - CMD_WR_BASE);
  assign w_rd_idx  = IW'(i_rx_data - CMD_RD_BASE);
  assign w_expired = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (i_rx_valid && w_is_wr) w_next = ST_WAIT_VAL;
      ST_WAIT_VAL: if (i_rx_valid || w_expired) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_idx_load = 1'b0;
    w_wr_en    = 1'b0;
    w_rd_req   = 1'b0;
    w_cmd_err  = 1'b0;
    w_tmo      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_rx_valid) begin
          if (w_is_wr)                     w_idx_load = 1'b1;
          else if (w_is_rd)                w_rd_req   = 1'b1;
          else if (i_rx_data != CMD_NOP)   w_cmd_err  = 1'b1;
        end
      end
      ST_WAIT_VAL: begin
        // A byte arriving in the expiry cycle still wins over the timeout.
        if (i_rx_valid)     w_wr_en = 1'b1;
        else if (w_expired) w_tmo   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || r_state != ST_WAIT_VAL || w_next != ST_WAIT_VAL) r_cnt <= '0;
    else                                                           r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
      r_idx         <= '0;
      r_wr_strobe   <= 1'b0;
      r_wr_index    <= '0;
      r_err_cmd     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_wr_strobe   <= w_wr_en;
      r_err_cmd     <= w_cmd_err;
      r_err_timeout <= w_tmo;
      if (w_idx_load) r_idx <= w_wr_idx;
      if (w_wr_en) begin
        r_regs[r_idx] <= i_rx_data;
        r_wr_index    <= r_idx;
      end
    end
  end

`ifdef UART_CMD_ECHO_EN
  assign w_tx_req  = w_rd_req | w_wr_en;
  assign w_tx_data = w_rd_req ? r_regs[w_rd_idx] : i_rx_data;
`else
  assign w_tx_req  = w_rd_req;
  assign w_tx_data = r_regs[w_rd_idx];
`endif

  uart_cmd_txslot u_txslot (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_req         (w_tx_req),
    .i_req_data    (w_tx_data),
    .i_tx_ready    (i_tx_ready),
    .o_tx_valid    (o_tx_valid),
    .o_tx_data     (o_tx_data),
    .o_err_overrun (o_err_overrun)
  );

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign o_regs_out[8*g +: 8] = r_regs[g];
  end

  assign o_wr_strobe   = r_wr_strobe;
  assign o_wr_index    = r_wr_index;
  assign o_err_cmd     = r_err_cmd;
  assign o_err_timeout = r_err_timeout;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - directed self-checking bench for uart_cmd_decoder
module tb_uart_cmd_decoder;

  localparam int NR  = 4;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          tx_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic [NR*8-1:0] regs_out;
  logic          wr_strobe;
  logic [1:0]    wr_index;
  logic          err_cmd;
  logic          err_timeout;
  logic          err_overrun;

  int total = 0;
  int bad   = 0;
  logic seen;

  always #5 clk = ~clk;

  uart_cmd_decoder #(.NUM_REGS(NR), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_rx_valid    (rx_valid),
    .i_rx_data     (rx_data),
    .i_tx_ready    (tx_ready),
    .o_tx_valid    (tx_valid),
    .o_tx_data     (tx_data),
    .o_regs_out    (regs_out),
    .o_wr_strobe   (wr_strobe),
    .o_wr_index    (wr_index),
    .o_err_cmd     (err_cmd),
    .o_err_timeout (err_timeout),
    .o_err_overrun (err_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the byte is sampled on the next posedge and we return
  // at the following negedge, where one-cycle pulses from that byte are visible.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    @(negedge clk);
    do_reset();
    chk("rst_regs", regs_out, 32'h0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_wrs", wr_strobe, 0);
    chk("rst_wri", wr_index, 0);
    chk("rst_errs", {err_cmd, err_timeout, err_overrun}, 0);

    send(8'h41);
    chk("t1_no_early_wr", wr_strobe, 0);
    send(8'h31);
    chk("t1_wrs", wr_strobe, 1);
    chk("t1_wri", wr_index, 0);
    chk("t1_regs", regs_out, 32'h0000_0031);
    chk("t1_errs", {err_cmd, err_timeout, err_overrun}, 0);
    @(negedge clk);
    chk("t1_wrs_pulse", wr_strobe, 0);

    tx_ready = 1'b1;
    send(8'h42);
    send(8'h32);
    chk("t2_wri", wr_index, 1);
    chk("t2_regs", regs_out, 32'h0000_3231);
    send(8'h62);
    chk("t2_txv", tx_valid, 1);
    chk("t2_txd", tx_data, 8'h32);
    @(negedge clk);
    chk("t2_txv_clr", tx_valid, 0);

    send(8'h43);
    seen = 1'b0;
    repeat (TMO - 1) begin
      @(negedge clk);
      if (err_timeout) seen = 1'b1;
    end
    chk("t3_tmo_early", seen, 0);
    @(negedge clk);
    chk("t3_tmo", err_timeout, 1);
    chk("t3_regs_kept", regs_out, 32'h0000_3231);
    chk("t3_no_wr", wr_strobe, 0);
    @(negedge clk);
    chk("t3_tmo_pulse", err_timeout, 0);
    send(8'h44);
    send(8'h34);
    chk("t3_reg3", regs_out, 32'h3400_3231);

    send(8'h43);
    repeat (TMO - 1) @(negedge clk);
    send(8'h77);
    chk("t3_edge_wr", wr_strobe, 1);
    chk("t3_edge_no_tmo", err_timeout, 0);
    chk("t3_edge_regs", regs_out, 32'h3477_3231);

    send(8'h7A);
    chk("t4_z", err_cmd, 1);
    send(8'h45);
    chk("t4_E", err_cmd, 1);
    send(8'h40);
    chk("t4_at", err_cmd, 1);
    send(8'h00);
    chk("t4_nop_err", err_cmd, 0);
    chk("t4_nop_regs", regs_out, 32'h3477_3231);
    chk("t4_nop_tx", tx_valid, 0);

    tx_ready = 1'b0;
    send(8'h61);
    chk("t5_txv", tx_valid, 1);
    chk("t5_txd", tx_data, 8'h31);
    chk("t5_no_ovr", err_overrun, 0);
    send(8'h62);
    chk("t5_ovr", err_overrun, 1);
    chk("t5_txd_held", tx_data, 8'h31);
    @(negedge clk);
    chk("t5_ovr_pulse", err_overrun, 0);
    chk("t5_txv_held", tx_valid, 1);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("t5_txv_clr", tx_valid, 0);

    tx_ready = 1'b0;
    send(8'h63);
    chk("t5_c_txd", tx_data, 8'h77);
    tx_ready = 1'b1;
    send(8'h64);
    chk("t5_reload_txv", tx_valid, 1);
    chk("t5_reload_txd", tx_data, 8'h34);
    chk("t5_reload_ovr", err_overrun, 0);
    @(negedge clk);
    chk("t5_reload_clr", tx_valid, 0);

    tx_ready = 1'b0;
    send(8'h61);
    send(8'h41);
    do_reset();
    chk("t6_regs", regs_out, 32'h0);
    chk("t6_txv", tx_valid, 0);
    send(8'h99);
    chk("t6_idle", err_cmd, 1);
    chk("t6_no_wr", wr_strobe, 0);
    send(8'h41);
    send(8'h55);
    chk("t6_wr", regs_out, 32'h0000_0055);
`ifdef UART_CMD_ECHO_EN
    chk("t6_echo_txv", tx_valid, 1);
    chk("t6_echo_txd", tx_data, 8'h55);
`else
    chk("t6_no_echo", tx_valid, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
